// File: rtl/ram_arb2.sv
// CPU/DMA request arbiter in front of the byte-laned 32-bit BRAM; CPU has fixed priority.
// Define ARB_STARVE_EN to force a DMA slot after MAX_WAIT back-to-back CPU grants.
module ram_arb2 #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic              cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic              dma_be,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ack,
  output logic [31:0]       dma_rdata,
  output logic              ram_wr,
  output logic              ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef struct packed {
    logic              wr;
    logic              be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("ram_arb2: MAX_WAIT must be at least 1");
  end

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  ram_cmd_t          cmd_q, cmd_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  ram_cmd_t cpu_cmd_c;
  ram_cmd_t dma_cmd_c;
  logic     force_dma_c;
  logic     grant_cpu_c;
  logic     grant_dma_c;

  assign cpu_cmd_c = '{wr: cpu_wr, be: cpu_be, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_cmd_c = '{wr: dma_wr, be: dma_be, addr: dma_addr, wdata: dma_wdata};

  // Grant decode; only consumed while the FSM sits in IDLE.
  assign grant_cpu_c = cpu_req && !force_dma_c;
  assign grant_dma_c = dma_req && !grant_cpu_c;

`ifdef ARB_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  assign force_dma_c = dma_req && (wait_q == WAIT_W'(MAX_WAIT));

  // Counts CPU wins that left a DMA request waiting; never exceeds MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (state_q == S_IDLE) begin
      if (!dma_req || grant_dma_c) begin
        wait_d = '0;
      end else if (grant_cpu_c) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign force_dma_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      cmd_q       <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_q       <= cmd_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Acks default low so they pulse for exactly the RESP cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_d       = cmd_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_cpu_c) begin
          state_d = S_ACCESS;
          owner_d = OWN_CPU;
          cmd_d   = cpu_cmd_c;
        end else if (grant_dma_c) begin
          state_d = S_ACCESS;
          owner_d = OWN_DMA;
          cmd_d   = dma_cmd_c;
        end
      end

      S_ACCESS: begin
        state_d  = S_RESP;
        cmd_d.wr = 1'b0;
        if (owner_q == OWN_CPU) begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = ram_rdata;
        end else begin
          dma_ack_d   = 1'b1;
          dma_rdata_d = ram_rdata;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_wr    = cmd_q.wr;
  assign ram_be    = cmd_q.be;
  assign ram_addr  = cmd_q.addr;
  assign ram_wdata = cmd_q.wdata;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural byte-laned RAM that acts on the falling edge.
module tb_ram_arb2;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_wr, cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  logic              dma_req, dma_wr, dma_be;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_ack;
  logic [31:0]       dma_rdata;
  logic              ram_wr, ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arb2 #(.ADDR_W(ADDR_W), .MAX_WAIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_wr    (dma_wr),
    .dma_be    (dma_be),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .ram_wr    (ram_wr),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural BRAM: word array, byte lane picked by addr[1:0] when be=1.
  logic [31:0] mem [0:(1<<15)-1];
  logic [14:0] ram_idx;
  assign ram_idx = ram_addr[ADDR_W-1:2];

  always @(negedge clk) begin
    if (ram_wr) begin
      if (ram_be) begin
        case (ram_addr[1:0])
          2'd0: mem[ram_idx][7:0]   <= ram_wdata[7:0];
          2'd1: mem[ram_idx][15:8]  <= ram_wdata[15:8];
          2'd2: mem[ram_idx][23:16] <= ram_wdata[23:16];
          default: mem[ram_idx][31:24] <= ram_wdata[31:24];
        endcase
      end else begin
        mem[ram_idx] <= ram_wdata;
      end
    end
    ram_rdata <= mem[ram_idx];
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wr, input logic be, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, output int ack_at, output logic [31:0] rd);
    ack_at = 0;
    rd = '0;
    cpu_req = 1'b1; cpu_wr = wr; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
    for (int i = 1; i <= 10 && ack_at == 0; i++) begin
      tick();
      if (cpu_ack) begin
        ack_at = i;
        rd = cpu_rdata;
      end
    end
    cpu_req = 1'b0; cpu_wr = 1'b0;
    tick();
  endtask

  task automatic dma_access(input logic wr, input logic be, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, output int ack_at, output logic [31:0] rd);
    ack_at = 0;
    rd = '0;
    dma_req = 1'b1; dma_wr = wr; dma_be = be; dma_addr = addr; dma_wdata = wdata;
    for (int i = 1; i <= 10 && ack_at == 0; i++) begin
      tick();
      if (dma_ack) begin
        ack_at = i;
        rd = dma_rdata;
      end
    end
    dma_req = 1'b0; dma_wr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [116:0] outs;
    rst_n = 1'b0;
    cpu_req = 0; cpu_wr = 0; cpu_be = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_wr = 0; dma_be = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) tick();
    outs = {ram_wr, ram_be, ram_addr, ram_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ram_wr, cpu_ack, dma_ack} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000", {ram_wr, cpu_ack, dma_ack});
    end
  endtask

  task automatic test_cpu_write();
    int wr_cnt = 0, wr_at = 0, ack_at = 0, ack_cnt = 0, dma_cnt = 0;
    logic wr_ok = 1'b1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_be = 1'b0; cpu_addr = 17'h00100; cpu_wdata = 32'hDEADBEEF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ram_wr) begin
        wr_cnt++;
        if (wr_at == 0) wr_at = i;
        if (ram_addr !== 17'h00100 || ram_wdata !== 32'hDEADBEEF || ram_be !== 1'b0) wr_ok = 1'b0;
      end
      if (cpu_ack) begin
        ack_cnt++;
        if (ack_at == 0) ack_at = i;
        cpu_req = 1'b0; cpu_wr = 1'b0;
      end
      if (dma_ack) dma_cnt++;
    end
    checks++;
    if (wr_cnt !== 1) begin failures++; $display("FAIL cpu_write_wr_cycles got=%0d exp=1", wr_cnt); end
    checks++;
    if (wr_at !== 1) begin failures++; $display("FAIL cpu_write_wr_cycle got=%0d exp=1", wr_at); end
    checks++;
    if (wr_ok !== 1'b1) begin failures++; $display("FAIL cpu_write_ram_fields got=%b exp=1", wr_ok); end
    checks++;
    if (ack_at !== 2) begin failures++; $display("FAIL cpu_write_ack_latency got=%0d exp=2", ack_at); end
    checks++;
    if (ack_cnt !== 1) begin failures++; $display("FAIL cpu_write_ack_count got=%0d exp=1", ack_cnt); end
    checks++;
    if (dma_cnt !== 0) begin failures++; $display("FAIL cpu_write_dma_ack got=%0d exp=0", dma_cnt); end
    checks++;
    if ({ram_wr, ram_addr, ram_wdata} !== {1'b0, 17'h00100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL ram_hold_in_idle got=%b/%h/%h exp=0/00100/deadbeef", ram_wr, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_cpu_readback();
    int ack_at;
    logic [31:0] rd;
    cpu_access(1'b0, 1'b0, 17'h00100, 32'h0, ack_at, rd);
    checks++;
    if (ack_at !== 2) begin failures++; $display("FAIL cpu_read_ack_latency got=%0d exp=2", ack_at); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_read_data got=%h exp=deadbeef", rd); end
    repeat (10) tick();
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cpu_rdata_hold got=%h exp=deadbeef", cpu_rdata);
    end
  endtask

  task automatic test_dma_preload();
    int ack_at;
    logic [31:0] rd;
    dma_access(1'b1, 1'b0, 17'h00200, 32'h12345678, ack_at, rd);
    checks++;
    if (ack_at !== 2) begin failures++; $display("FAIL dma_write_ack_latency got=%0d exp=2", ack_at); end
    checks++;
    if (mem[15'h0080] !== 32'h12345678) begin
      failures++;
      $display("FAIL dma_write_mem got=%h exp=12345678", mem[15'h0080]);
    end
  endtask

  task automatic test_simultaneous();
    int cpu_at = 0, dma_at = 0;
    logic [31:0] cpu_rd = '0, dma_rd = '0;
    logic wr_seen = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00100;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 17'h00200;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ram_wr) wr_seen = 1'b1;
      if (cpu_ack && cpu_at == 0) begin cpu_at = i; cpu_rd = cpu_rdata; cpu_req = 1'b0; end
      if (dma_ack && dma_at == 0) begin dma_at = i; dma_rd = dma_rdata; dma_req = 1'b0; end
    end
    checks++;
    if (cpu_at !== 2) begin failures++; $display("FAIL simul_cpu_ack got=%0d exp=2", cpu_at); end
    checks++;
    if (dma_at !== 5) begin failures++; $display("FAIL simul_dma_ack got=%0d exp=5", dma_at); end
    checks++;
    if (cpu_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL simul_cpu_data got=%h exp=deadbeef", cpu_rd); end
    checks++;
    if (dma_rd !== 32'h12345678) begin failures++; $display("FAIL simul_dma_data got=%h exp=12345678", dma_rd); end
    checks++;
    if (wr_seen !== 1'b0) begin failures++; $display("FAIL simul_ram_wr got=%b exp=0", wr_seen); end
  endtask

  task automatic test_dma_byte_write();
    int ack_at;
    logic [31:0] rd;
    dma_access(1'b1, 1'b1, 17'h00102, 32'h00AB0000, ack_at, rd);
    checks++;
    if (ack_at !== 2) begin failures++; $display("FAIL dma_byte_ack got=%0d exp=2", ack_at); end
    cpu_access(1'b0, 1'b0, 17'h00100, 32'h0, ack_at, rd);
    checks++;
    if (rd !== 32'hDEABBEEF) begin failures++; $display("FAIL dma_byte_merge got=%h exp=deabbeef", rd); end
  endtask

  task automatic test_starvation();
    int n = 0, cpu_tot = 0, dma_tot = 0, n_acc;
    logic [63:0] seq = '0;
`ifdef ARB_STARVE_EN
    n_acc = 10;
`else
    n_acc = 50;
`endif
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 17'h00100;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 17'h00200;
    for (int i = 0; i < 200 && n < n_acc; i++) begin
      tick();
      if (cpu_ack) begin cpu_tot++; n++; end
      if (dma_ack) begin seq[n] = 1'b1; dma_tot++; n++; dma_req = 1'b0; end
    end
    cpu_req = 1'b0;
    checks++;
    if (n !== n_acc) begin failures++; $display("FAIL starve_access_count got=%0d exp=%0d", n, n_acc); end
`ifdef ARB_STARVE_EN
    checks++;
    if (seq[9:0] !== 10'h100) begin
      failures++;
      $display("FAIL starve_grant_order got=%b exp=0100000000", seq[9:0]);
    end
    repeat (2) tick();
`else
    checks++;
    if (dma_tot !== 0) begin failures++; $display("FAIL fixed_prio_dma_acks got=%0d exp=0", dma_tot); end
    begin
      int dma_at = 0;
      logic [31:0] rd = '0;
      for (int i = 1; i <= 10 && dma_at == 0; i++) begin
        tick();
        if (dma_ack) begin dma_at = i; rd = dma_rdata; end
      end
      dma_req = 1'b0;
      checks++;
      if (rd !== 32'h12345678 || dma_at == 0) begin
        failures++;
        $display("FAIL dma_after_cpu_idle got=%h at=%0d exp=12345678", rd, dma_at);
      end
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    int ack_at, ack_seen = 0;
    logic [31:0] rd;
    cpu_access(1'b1, 1'b0, 17'h00300, 32'h0BADF00D, ack_at, rd);
    checks++;
    if (ack_at !== 2) begin failures++; $display("FAIL preload_300_ack got=%0d exp=2", ack_at); end
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_be = 1'b0; cpu_addr = 17'h00300; cpu_wdata = 32'hFFFFFFFF;
    tick();
    checks++;
    if (ram_wr !== 1'b1) begin failures++; $display("FAIL abort_wr_launched got=%b exp=1", ram_wr); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_wr !== 1'b0) begin failures++; $display("FAIL abort_wr_async_drop got=%b exp=0", ram_wr); end
    cpu_req = 1'b0; cpu_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_ack) ack_seen++;
    end
    checks++;
    if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL abort_rdata_reset got=%h exp=0", cpu_rdata); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack) ack_seen++;
    end
    checks++;
    if (ack_seen !== 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", ack_seen); end
    checks++;
    if (mem[15'h00C0] !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL abort_mem_unchanged got=%h exp=0badf00d", mem[15'h00C0]);
    end
    cpu_access(1'b0, 1'b0, 17'h00300, 32'h0, ack_at, rd);
    checks++;
    if (ack_at !== 2 || rd !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL abort_recovery got=%0d/%h exp=2/0badf00d", ack_at, rd);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_readback();
    test_dma_preload();
    test_simultaneous();
    test_dma_byte_write();
    test_starvation();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
